gray_pixel_streamer: RTL and testbench

//  Read-side counterpart to the IPU grayscale store path. After the MIPS/IPU run has packed 8-bit grayscale

---
 rtl/ipu_pkg.sv | 23 ++
 rtl/gray_pixel_streamer_unpacker.sv | 54 +++++
 rtl/gray_pixel_streamer.sv | 137 +++++++++++++
 tb/tb_gray_pixel_streamer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ipu_pkg.sv
// ---------------------------------------------------------------------------
// ipu_pkg
// Purpose : Shared constants and FSM state encoding for the IPU grayscale
//           read-side streamer (gray_pixel_streamer) and its word unpacker.
// Contents: WORD_W, PIX_W, PIX_PER_WORD, ADDR_W, CNT_W and state_t.
// ---------------------------------------------------------------------------
package ipu_pkg;

    localparam int WORD_W       = 32;
    localparam int PIX_W        = 8;
    localparam int PIX_PER_WORD = WORD_W / PIX_W;
    localparam int ADDR_W       = 6;
    localparam int CNT_W        = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SEND   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/gray_pixel_streamer_unpacker.sv
// ---------------------------------------------------------------------------
// gray_word_unpacker
// Purpose : Holds one fetched memory word and selects the current pixel slot.
//           Pixel 0 sits in the least significant bits of the word.
// Ports   :
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high, clears word and slot
//   load       in   capture load_word, restart at slot 0
//   load_word  in   WORD_W word returned by memory
//   advance    in   move to the next slot (one pixel consumed)
//   pix        out  PIX_W pixel at the current slot
//   slot_wrap  out  current slot is the last one in the word
// ---------------------------------------------------------------------------
module gray_word_unpacker #(
    parameter int WORD_W       = ipu_pkg::WORD_W,
    parameter int PIX_W        = ipu_pkg::PIX_W,
    parameter int PIX_PER_WORD = WORD_W / PIX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    input  logic              advance,
    output logic [PIX_W-1:0]  pix,
    output logic              slot_wrap
);
    import ipu_pkg::*;

    localparam int SLOT_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    logic [WORD_W-1:0] word_buf;
    logic [SLOT_W-1:0] slot;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_buf <= '0;
            slot     <= '0;
        end else if (load) begin
            word_buf <= load_word;
            slot     <= '0;
        end else if (advance) begin
            // explicit wrap keeps non-power-of-two word layouts correct
            if (slot_wrap) begin
                slot <= '0;
            end else begin
                slot <= slot + 1'b1;
            end
        end
    end

    assign slot_wrap = (slot == SLOT_W'(PIX_PER_WORD - 1));
    assign pix       = word_buf[slot * PIX_W +: PIX_W];

endmodule

// File: rtl/gray_pixel_streamer.sv
// ---------------------------------------------------------------------------
// gray_pixel_streamer
// Purpose : Fetches packed grayscale words (PIX_PER_WORD pixels per word)
//           from a synchronous data-memory read port and streams the pixels
//           one per valid/ready transfer, flagging the final pixel.
// Ports   :
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high; aborts any run
//   start        in   1-cycle pulse, accepted only in IDLE
//   base_addr    in   first word address, sampled on accepted start
//   num_pixels   in   pixel count, sampled on accepted start
//   mem_rd_en    out  read strobe (data returns one cycle later)
//   mem_rd_addr  out  word address for the read
//   mem_rd_data  in   read data
//   pix_data     out  current pixel (0 when pix_valid is low)
//   pix_valid    out  pix_data valid
//   pix_ready    in   sink accepts
//   pix_last     out  final pixel of the run
//   busy         out  high in every state except IDLE
//   done         out  1-cycle pulse after the run completes
// ---------------------------------------------------------------------------
module gray_pixel_streamer #(
    parameter int WORD_W = ipu_pkg::WORD_W,
    parameter int PIX_W  = ipu_pkg::PIX_W,
    parameter int ADDR_W = ipu_pkg::ADDR_W,
    parameter int CNT_W  = ipu_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_pixels,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [WORD_W-1:0] mem_rd_data,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last,
    output logic              busy,
    output logic              done
);
    import ipu_pkg::*;

    localparam int PPW = WORD_W / PIX_W;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic [PIX_W-1:0]  unp_pix;
    logic              slot_wrap;
    logic              xfer;
    logic              load_word;

    assign xfer      = pix_valid & pix_ready;
    // memory data is on the bus during WAIT (read issued in FETCH)
    assign load_word = (state == ST_WAIT);

    gray_word_unpacker #(
        .WORD_W       (WORD_W),
        .PIX_W        (PIX_W),
        .PIX_PER_WORD (PPW)
    ) u_unpacker (
        .clk       (clk),
        .reset     (reset),
        .load      (load_word),
        .load_word (mem_rd_data),
        .advance   (xfer),
        .pix       (unp_pix),
        .slot_wrap (slot_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            mem_rd_en <= 1'b0;
            pix_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // done is visible in the first IDLE cycle; a start
                    // arriving together with it belongs to the old run
                    if (start && !done) begin
                        addr      <= base_addr;
                        remaining <= num_pixels;
                        if (num_pixels == '0) begin
                            state <= ST_FINISH;
                        end else begin
                            state     <= ST_FETCH;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    state     <= ST_SEND;
                    pix_valid <= 1'b1;
                end
                ST_SEND: begin
                    if (xfer) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            pix_valid <= 1'b0;
                            state     <= ST_FINISH;
                        end else if (slot_wrap) begin
                            // address wraps modulo 2^ADDR_W by width
                            pix_valid <= 1'b0;
                            addr      <= addr + 1'b1;
                            mem_rd_en <= 1'b1;
                            state     <= ST_FETCH;
                        end
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_addr = addr;
    assign busy        = (state != ST_IDLE);
    assign pix_data    = pix_valid ? unp_pix : '0;
    assign pix_last    = pix_valid & (remaining == CNT_W'(1));

endmodule

// File: tb/tb_gray_pixel_streamer.sv
module tb_gray_pixel_streamer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  base_addr;
    logic [8:0]  num_pixels;
    logic        mem_rd_en;
    logic [5:0]  mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;
    logic        busy;
    logic        done;

    logic [31:0] mem [64];
    logic [8:0]  sb [$];
    logic [5:0]  rd_log [$];

    int n_assert;
    int n_fail;

    gray_pixel_streamer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .num_pixels  (num_pixels),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_last    (pix_last),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // synchronous read port: data one cycle after mem_rd_en
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {13'd0, mem_rd_en, mem_rd_addr, pix_data, pix_valid, pix_last, busy, done}, 32'd0);
    endtask

    // mode 0: ready tied high; mode 1: ready pattern 1,0,0,1,0,0,...
    task automatic run_stream(input logic [5:0] base, input logic [8:0] num,
                              input int mode, input bit poke_busy);
        int          first_v, last_x, done_k, busy_cnt, nreads;
        bit          seen_done, prev_stall;
        logic [7:0]  prev_data;
        logic        prev_last;
        logic [31:0] w;
        logic [5:0]  a;
        logic [8:0]  e;
        logic [5:0]  exp_addr [$];
        first_v = -1; last_x = -1; done_k = -1; busy_cnt = 0;
        seen_done = 0; prev_stall = 0; prev_data = '0; prev_last = 0;
        rd_log.delete();
        for (int i = 0; i < int'(num); i++) begin
            a = base + 6'(i / 4);
            w = mem[a];
            sb.push_back({(i == int'(num) - 1), w[8 * (i % 4) +: 8]});
        end
        nreads = (int'(num) + 3) / 4;
        for (int j = 0; j < nreads; j++) exp_addr.push_back(base + 6'(j));

        base_addr  = base;
        num_pixels = num;
        start      = 1'b1;
        pix_ready  = 1'b1;
        for (int k = 0; k < 300 && !seen_done; k++) begin
            @(negedge clk);
            if (mem_rd_en) rd_log.push_back(mem_rd_addr);
            if (busy) busy_cnt++;
            if (pix_valid && first_v < 0) first_v = k;
            if (prev_stall) begin
                chk("stall_hold", {22'd0, pix_valid, pix_last, pix_data}, {22'd0, 1'b1, prev_last, prev_data});
            end
            if (pix_valid && pix_ready) begin
                last_x = k;
                if (sb.size() == 0) begin
                    chk("pix_extra", {23'd0, pix_last, pix_data}, 32'h1ff);
                end else begin
                    e = sb.pop_front();
                    chk("pix", {23'd0, pix_last, pix_data}, {23'd0, e});
                end
            end
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
            prev_last  = pix_last;
            if (done) begin
                seen_done = 1;
                done_k    = k;
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
            @(posedge clk);
            #1;
            start = poke_busy && (k + 1 == 5);
            if (poke_busy && (k + 1 == 5)) begin
                base_addr  = 6'd10;
                num_pixels = 9'd3;
            end
            pix_ready = (mode == 0) ? 1'b1 : ((k + 1) % 3 == 0);
        end
        start = 1'b0;
        chk("done_seen", {31'd0, seen_done}, 32'd1);
        @(negedge clk);
        chk("done_single", {30'd0, done, busy}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);
        chk("rd_count", rd_log.size(), exp_addr.size());
        if (rd_log.size() == exp_addr.size()) begin
            foreach (exp_addr[j]) chk("rd_addr", {26'd0, rd_log[j]}, {26'd0, exp_addr[j]});
        end
        if (num == 0) begin
            chk("zero_no_valid", first_v, -1);
            chk("zero_done_lat", done_k, 2);
            chk("zero_busy_cycles", busy_cnt, 1);
        end else begin
            chk("first_valid_lat", first_v, 3);
            chk("done_after_last", done_k, last_x + 2);
        end
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = 32'h44332211;
        mem[1]  = 32'h88776655;
        mem[10] = 32'hEEEEEEEE;
        mem[63] = 32'hDDCCBBAA;
        reset = 1'b1; start = 1'b0; base_addr = '0; num_pixels = '0; pix_ready = 1'b1;
        mem_rd_data = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset_state");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // reset in the middle of SEND
        base_addr = 6'd0; num_pixels = 9'd8; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("in_send", {30'd0, pix_valid, busy}, 32'd3);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_idle("reset_mid_run_1");
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk_idle("reset_mid_run_2");
        @(posedge clk); #1;

        // full two-word run
        run_stream(6'd0, 9'd8, 0, 0);
        // partial last word
        run_stream(6'd0, 9'd6, 0, 0);
        // backpressure
        run_stream(6'd0, 9'd8, 1, 0);
        // zero-length run
        run_stream(6'd0, 9'd0, 0, 0);

        // start coincident with done is ignored
        base_addr = 6'd0; num_pixels = 9'd0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        num_pixels = 9'd4; start = 1'b1;
        @(negedge clk);
        chk("coinc_done", {31'd0, done}, 32'd1);
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("coinc_start_ignored", {30'd0, busy, mem_rd_en}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("coinc_no_read", {30'd0, busy, mem_rd_en}, 32'd0);
        @(posedge clk); #1;

        // address wrap with a start pulsed while busy
        run_stream(6'd63, 9'd8, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
